// File: rtl/bcd_serial_alu.sv
// Multi-digit packed-BCD add/subtract engine.
// One 2-digit BCD add stage is reused once per clock, LSB byte first, and the
// decimal carry ripples between bytes through a register. Subtraction is
// A + 9s-complement(B) + 1, so carry_out = 1 means no borrow.
module bcd_serial_alu #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic                op_sub,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [8*NBYTES-1:0] result,
    output logic                carry_out,
    output logic                digit_err,
    output logic                busy
);

    localparam int W  = 8 * NBYTES;
    localparam int ND = 2 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [W-1:0]    opa_r;
    logic [W-1:0]    opb_r;
    logic [IW-1:0]   idx_r;
    logic            carry_r;

    logic [7:0]      byte_a_s;
    logic [7:0]      byte_b_s;
    logic [4:0]      lo_s;
    logic [4:0]      hi_s;
    logic [7:0]      byte_sum_s;
    logic            byte_carry_s;
    logic            last_s;

    // Single BCD digit add: {carry, digit}. Sums above 9 are corrected by +6;
    // out-of-range input digits go through the same rule unchanged.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       cin);
        logic [4:0] s;
        logic [4:0] adj;
        logic [4:0] r;
        s   = {1'b0, x} + {1'b0, y} + {4'd0, cin};
        adj = s + 5'd6;
        if (s > 5'd9) begin
            r = {1'b1, adj[3:0]};
        end else begin
            r = {1'b0, s[3:0]};
        end
        return r;
    endfunction

    // True when any 4-bit digit of the operand is above 9.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // Per-digit nines complement, truncated to 4 bits for invalid digits.
    function automatic logic [W-1:0] nines_comp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'd9 - v[i*4 +: 4];
        end
        return r;
    endfunction

    // Shared 2-digit add stage operating on the byte selected by idx_r.
    always_comb begin
        byte_a_s     = opa_r[{idx_r, 3'b000} +: 8];
        byte_b_s     = opb_r[{idx_r, 3'b000} +: 8];
        lo_s         = bcd_digit_add(byte_a_s[3:0], byte_b_s[3:0], carry_r);
        hi_s         = bcd_digit_add(byte_a_s[7:4], byte_b_s[7:4], lo_s[4]);
        byte_sum_s   = {hi_s[3:0], lo_s[3:0]};
        byte_carry_s = hi_s[4];
        last_s       = (idx_r == IW'(NBYTES - 1));
    end

    // Control FSM, operand/carry registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            opa_r       <= '0;
            opb_r       <= '0;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            result      <= '0;
            carry_out   <= 1'b0;
            digit_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        opa_r       <= a;
                        opb_r       <= op_sub ? nines_comp(b) : b;
                        carry_r     <= op_sub;
                        digit_err   <= has_bad_digit(a) | has_bad_digit(b);
                        idx_r       <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= RUN;
                    end
                end
                RUN: begin
                    result[{idx_r, 3'b000} +: 8] <= byte_sum_s;
                    carry_r                      <= byte_carry_s;
                    if (last_s) begin
                        carry_out <= byte_carry_s;
                        res_valid <= 1'b1;
                        idx_r     <= '0;
                        state_r   <= DONE;
                    end else begin
                        idx_r     <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    start_ready <= 1'b1;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                    idx_r       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Scoreboard bench for bcd_serial_alu: directed corner cases plus randomized
// add/subtract commands checked against a decimal-integer reference model.
module tb_bcd_serial_alu;

    localparam int NB = 4;
    localparam int W  = 8 * NB;
    localparam int ND = 2 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         digit_err;
    logic         busy;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         err;
        bit           chk_res;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    bcd_serial_alu #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_sub     (op_sub),
        .a          (a),
        .b          (b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result),
        .carry_out  (carry_out),
        .digit_err  (digit_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r;
        r = 0;
        for (int i = ND - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint n);
        logic [W-1:0] r;
        longint       t;
        t = n;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit any_bad(input logic [W-1:0] v);
        bit bad;
        bad = 0;
        for (int i = 0; i < ND; i++) if (v[i*4 +: 4] > 4'd9) bad = 1;
        return bad;
    endfunction

    // Reference: decimal arithmetic modulo 10^(2*NB).
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub);
        exp_t   e;
        longint m, x, y, s;
        m = 1;
        for (int i = 0; i < ND; i++) m = m * 10;
        x = bcd2int(av);
        y = bcd2int(bv);
        if (sub) begin
            e.c = (x >= y);
            s   = (x - y + m) % m;
        end else begin
            s   = x + y;
            e.c = (s >= m);
            s   = s % m;
        end
        e.res     = int2bcd(s);
        e.err     = any_bad(av) | any_bad(bv);
        e.chk_res = !e.err;
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic err);
        exp_t e;
        e.res = r; e.c = c; e.err = err; e.chk_res = 1;
        return e;
    endfunction

    // Monitor: compare every delivered result with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h expected=none", result);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (e.chk_res) begin
                        checkw("result", result, e.res);
                        check1("carry_out", carry_out, e.c);
                    end
                    check1("digit_err", digit_err, e.err);
                end
            end
        end
    end

    // Issue one command; expectation is pushed on the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                        input bit push, input exp_t e, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        a = av; b = bv; op_sub = sub; start_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            waited++;
            if (start_ready === 1'b1) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 expected=1");
            start_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) sbq.push_back(e);
            #1 start_valid = 1'b0;
        end
    endtask

    // Wait for all outstanding results, optionally with random backpressure.
    task automatic drain(input bit rnd);
        for (int k = 0; k < 2000 && sbq.size() != 0; k++) begin
            @(posedge clk);
            #1;
            if (rnd) res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", sbq.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_start_ready"}, start_ready, 1'b1);
        check1({tag, "_res_valid"}, res_valid, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        checkw({tag, "_result"}, result, '0);
        check1({tag, "_carry_out"}, carry_out, 1'b0);
        check1({tag, "_digit_err"}, digit_err, 1'b0);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        rst_n = 1'b0; start_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; res_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: result valid exactly NB edges after the accepting edge.
        send(32'h12345678, 32'h87654321, 1'b0, 1, mk(32'h99999999, 1'b0, 1'b0), w);
        check1("busy_after_accept", busy, 1'b1);
        for (int k = 1; k <= NB; k++) begin
            @(posedge clk);
            #1;
            if (k == NB - 1) check1("latency_not_early", res_valid, 1'b0);
            if (k == NB)     check1("latency_exact", res_valid, 1'b1);
        end
        drain(0);

        // Directed arithmetic corners.
        send(32'h99999999, 32'h00000001, 1'b0, 1, mk(32'h00000000, 1'b1, 1'b0), w); drain(0);
        send(32'h00000009, 32'h00000000, 1'b0, 1, mk(32'h00000009, 1'b0, 1'b0), w); drain(0);
        send(32'h00000005, 32'h00000003, 1'b1, 1, mk(32'h00000002, 1'b1, 1'b0), w); drain(0);
        send(32'h00000003, 32'h00000005, 1'b1, 1, mk(32'h99999998, 1'b0, 1'b0), w); drain(0);
        send(32'h50505050, 32'h50505050, 1'b1, 1, mk(32'h00000000, 1'b1, 1'b0), w); drain(0);
        // Invalid digit 0xA: 10 > 9 gives digit 0 with carry into the tens digit.
        send(32'h0000000A, 32'h00000000, 1'b0, 1, mk(32'h00000010, 1'b0, 1'b1), w); drain(0);
        send(32'h00000001, 32'h00000001, 1'b0, 1, mk(32'h00000002, 1'b0, 1'b0), w); drain(0);

        // Backpressure: hold the result in DONE while start_valid pulses.
        res_ready = 1'b0;
        send(32'h12345678, 32'h11111111, 1'b0, 1, mk(32'h23456789, 1'b0, 1'b0), w);
        for (int k = 0; k < 20 && res_valid !== 1'b1; k++) @(negedge clk);
        check1("bp_res_valid", res_valid, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            start_valid = (k % 2 == 0);
            a = $urandom();
            b = $urandom();
            @(negedge clk);
            checkw("bp_result_stable", result, 32'h23456789);
            check1("bp_start_ready", start_ready, 1'b0);
            check1("bp_res_valid_held", res_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        res_ready = 1'b1;
        send(32'h00000250, 32'h00000750, 1'b0, 1, mk(32'h00001000, 1'b0, 1'b0), w);
        checks++;
        if (w != 2) begin
            errors++;
            $display("FAIL bp_reaccept_cycles actual=%0d expected=2", w);
        end
        drain(0);

        // Asynchronous reset in the middle of RUN discards the command.
        send(32'h11111111, 32'h22222222, 1'b0, 0, mk('0, 1'b0, 1'b0), w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h45454545, 32'h54545454, 1'b0, 1, mk(32'h99999999, 1'b0, 1'b0), w);
        drain(0);

        // Randomized commands with random backpressure.
        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, ND - 1) * 4 +: 4] = 4'($urandom_range(10, 15));
            e = model(ra, rb, rs);
            send(ra, rb, rs, 1, e, w);
            drain(1);
        end

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=%0d expected=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
